// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_pkg
//  Description : Shared types and constants for the 12-bit countdown timer.
//                - state_t       : control FSM encoding (IDLE/RUN/PAUSED/DONE)
//                - DEFAULT_WIDTH : default counter width
//                - PRESCALE_MAX  : largest legal prescale ratio
//  Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int PRESCALE_MAX  = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides the enable stream by PRESCALE. The internal counter
//                advances only while en is high and wraps on the tick, so a
//                tick is produced on every PRESCALE-th enabled cycle.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                clear - synchronous clear of the phase counter
//                en    - count enable
//                tick  - high in the enabled cycle that completes a period
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  import countdown_pkg::*;

  // Sized for the largest legal ratio so any PRESCALE in 1..4096 fits.
  localparam int            CW     = $clog2(PRESCALE_MAX);
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  // With PRESCALE=1 the counter sits at 0 == C_LAST, so tick follows en.
  assign tick = en && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_12b.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_12b
//  Description : Loadable down-counting interval timer with start/pause
//                control, optional prescaler and auto-reload on expiry.
//  Ports       : clk         - system clock
//                reset       - synchronous active-high reset
//                load        - copy b into count and reload register, go IDLE
//                start       - begin / resume counting
//                pause       - freeze counting while running
//                reload_mode - 1: reload on expiry, 0: one-shot
//                b           - load value
//                c           - current count
//                busy        - high while running
//                done        - one-cycle expiry pulse
//                zero        - c == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_12b
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             reload_mode,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             w_done_next;

  logic             w_tick;
  logic             w_prescale_en;
  logic             w_count_zero;
  logic             w_count_one;
  logic             w_rearm;

  assign w_count_zero = (r_count == '0);
  assign w_count_one  = (r_count == WIDTH'(1));
  // Auto-reload only makes sense with a nonzero reload value; otherwise the
  // expiry falls back to one-shot behaviour.
  assign w_rearm      = reload_mode && (r_reload != '0);

  // The prescaler must not advance on the edge where pause or load wins,
  // so that a paused timer resumes at the same phase.
  assign w_prescale_en = (r_state == ST_RUN) && !pause && !load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .en    (w_prescale_en),
    .tick  (w_tick)
  );

  // Reload register only changes on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= b;
    end
  end

  // State register (also holds count and the registered done pulse).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic. load dominates; start in RUN is a no-op so a
  // simultaneous pause still takes effect there.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    if (load) begin
      w_state_next = ST_IDLE;
      w_count_next = b;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_count_zero) begin
              w_state_next = ST_DONE;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end
        ST_PAUSED: begin
          if (start && !w_count_zero) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_next = ST_PAUSED;
          end else if (w_tick) begin
            if (w_count_one) begin
              w_done_next = 1'b1;
              if (w_rearm) begin
                w_count_next = r_reload;
              end else begin
                w_count_next = '0;
                w_state_next = ST_DONE;
              end
            end else if (!w_count_zero) begin
              w_count_next = r_count - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            w_count_next = r_reload;
            if (r_reload != '0) begin
              w_state_next = ST_RUN;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    c    = r_count;
    busy = (r_state == ST_RUN);
    done = r_done;
    zero = w_count_zero;
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_12b.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer_12b
//  Description : Directed self-checking bench for countdown_timer_12b.
//                dut1 runs with PRESCALE=1, dut4 with PRESCALE=4; both share
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_12b;
  import countdown_pkg::*;

  logic        clk = 1'b0;
  logic        reset, load, start, pause, reload_mode;
  logic [11:0] b;
  logic [11:0] c1, c4;
  logic        busy1, done1, zero1;
  logic        busy4, done4, zero4;

  int n_checks = 0;
  int n_errors = 0;
  int n_active = 0;
  logic active_en = 1'b0;
  int cycles;

  always #5 clk = ~clk;

  countdown_timer_12b #(.WIDTH(12), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .reload_mode(reload_mode), .b(b), .c(c1), .busy(busy1), .done(done1),
    .zero(zero1)
  );

  countdown_timer_12b #(.WIDTH(12), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .reload_mode(reload_mode), .b(b), .c(c4), .busy(busy4), .done(done4),
    .zero(zero4)
  );

  // Cycles spent actively counting (running and not being paused).
  always @(negedge clk) begin
    if (active_en && busy1 && !pause) n_active++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [11:0] exp_c [5] = '{12'd1, 12'd2, 12'd1, 12'd2, 12'd1};
  logic        exp_d [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    reload_mode = 1'b0; b = 12'd0;
    step(2);
    reset = 1'b0;
    // Reset state
    check("rst_c",    c1,    0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_zero", zero1, 1);
    check("rst_c4",   c4,    0);

    // One-shot, PRESCALE=1, load 3
    load = 1'b1; b = 12'd3; step(1); load = 1'b0;
    check("ld3_c",    c1,    3);
    check("ld3_zero", zero1, 0);
    start = 1'b1; step(1); start = 1'b0;
    check("run_busy", busy1, 1);
    check("run_c3",   c1,    3);
    step(1); check("run_c2", c1, 2);
    step(1); check("run_c1", c1, 1); check("run_d1", done1, 0);
    step(1);
    check("exp_c0",    c1,    0);
    check("exp_done",  done1, 1);
    check("exp_busy",  busy1, 0);
    check("exp_zero",  zero1, 1);
    check("exp_state", 32'(dut1.r_state), 32'(ST_DONE));
    step(1);
    check("post_done", done1, 0);
    check("post_c",    c1,    0);
    // start from DONE with nonzero reload value restarts
    start = 1'b1; step(1); start = 1'b0;
    check("rest_c",    c1,    3);
    check("rest_busy", busy1, 1);

    // PRESCALE=4, load 2
    reset = 1'b1; step(1); reset = 1'b0;
    load = 1'b1; b = 12'd2; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    check("ps4_busy", busy4, 1);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 3) check("ps4_c_i3", c4, 2);
      if (i == 4) check("ps4_c_i4", c4, 1);
      if (done4) begin
        cycles = i;
        break;
      end
    end
    check("ps4_done_lat", cycles, 8);
    check("ps4_zero", zero4, 1);

    // Auto-reload, load 2: 2,1,2,1,...
    reload_mode = 1'b1;
    load = 1'b1; b = 12'd2; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    check("ar_c0", c1, 2);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("ar_c%0d", i + 1), c1, exp_c[i]);
      check($sformatf("ar_d%0d", i + 1), done1, exp_d[i]);
      check($sformatf("ar_busy%0d", i + 1), busy1, 1);
    end

    // Pause: load 5, two decrements, pause 10 cycles, resume
    reload_mode = 1'b0;
    load = 1'b1; b = 12'd5; step(1); load = 1'b0;
    n_active = 0; active_en = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    step(1); check("pz_c4", c1, 4);
    step(1); check("pz_c3", c1, 3);
    pause = 1'b1;
    step(1);
    check("pz_busy",  busy1, 0);
    check("pz_state", 32'(dut1.r_state), 32'(ST_PAUSED));
    for (int i = 0; i < 9; i++) begin
      step(1);
      check($sformatf("pz_hold%0d", i), c1, 3);
    end
    pause = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    check("pz_resume_busy", busy1, 1);
    check("pz_resume_c",    c1,    3);
    step(1); check("pz_c2", c1, 2);
    step(1); check("pz_c1", c1, 1);
    step(1); check("pz_c0", c1, 0); check("pz_done", done1, 1);
    step(1);
    active_en = 1'b0;
    check("pz_active", n_active, 5);

    // load and start together: load wins
    load = 1'b1; start = 1'b1; b = 12'd7; step(1); load = 1'b0; start = 1'b0;
    check("ls_c",     c1, 7);
    check("ls_state", 32'(dut1.r_state), 32'(ST_IDLE));
    check("ls_busy",  busy1, 0);
    b = 12'd100;
    step(3);
    check("ls_hold_c", c1,    7);
    check("ls_hold_b", busy1, 0);

    // reset together with load
    reset = 1'b1; load = 1'b1; b = 12'd9; step(1); reset = 1'b0; load = 1'b0;
    check("rl_c",     c1, 0);
    check("rl_state", 32'(dut1.r_state), 32'(ST_IDLE));

    // Zero-count load
    load = 1'b1; b = 12'd0; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    check("z_done",  done1, 1);
    check("z_state", 32'(dut1.r_state), 32'(ST_DONE));
    check("z_c",     c1, 0);
    step(1);
    check("z_done_off", done1, 0);
    start = 1'b1; step(1); start = 1'b0;
    check("z2_done",  done1, 0);
    check("z2_state", 32'(dut1.r_state), 32'(ST_DONE));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("z2_c%0d", i), c1, 0);
      check($sformatf("z2_zero%0d", i), zero1, 1);
      check($sformatf("z2_d%0d", i), done1, 0);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
